// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the burst arbiter.
// Holds FSM encoding, widths and the round-robin pick.
package mem_arb_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;
    localparam int LEN_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Winner index: sole requester, or the one that did not go last.
    function automatic logic pick_owner(
        input logic r0,
        input logic r1,
        input logic last
    );
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/mem_sync_16x8.sv
// Single-port scratch memory.
// Synchronous write, registered read, array never reset.
module mem_sync_16x8 #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // One access per cycle: write or registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin burst arbiter for two requesters.
// Serialises bursts onto the scratch memory port.
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [DW-1:0]    wdata0,
    input  logic [DW-1:0]    wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [DW-1:0]    rdata0,
    output logic [DW-1:0]    rdata1
);

    arb_state_t       state, nxt_state;
    logic             owner, nxt_owner;
    logic             we_q, nxt_we;
    logic [AW-1:0]    ptr, nxt_ptr;
    logic [LEN_W-1:0] cnt, nxt_cnt;
    logic             last_owner, nxt_last;
    logic             win;

    logic             busy;
    logic             mem_we;
    logic             mem_re;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic [DW-1:0]    hold0, hold1;

    assign busy = (state == BURST);
    assign gnt0 = busy & ~owner;
    assign gnt1 = busy &  owner;
    assign ack0 = busy & ~owner;
    assign ack1 = busy &  owner;

    // A reset edge must not commit the beat in flight.
    assign mem_we    = busy &  we_q & ~reset;
    assign mem_re    = busy & ~we_q & ~reset;
    assign mem_wdata = owner ? wdata1 : wdata0;

    // Registered read word is live while rvalid, else the held copy.
    assign rdata0 = rvalid0 ? mem_rdata : hold0;
    assign rdata1 = rvalid1 ? mem_rdata : hold1;

    mem_sync_16x8 #(
        .DW(DW),
        .AW(AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (ptr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // Next-state: arbitrate in IDLE, step pointer and count in BURST.
    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        nxt_we    = we_q;
        nxt_ptr   = ptr;
        nxt_cnt   = cnt;
        nxt_last  = last_owner;
        win       = pick_owner(req0, req1, last_owner);
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    nxt_state = BURST;
                    nxt_owner = win;
                    nxt_we    = win ? we1 : we0;
                    nxt_ptr   = win ? addr1 : addr0;
                    nxt_cnt   = win ? len1 : len0;
                    nxt_last  = win;
                end
            end
            BURST: begin
                nxt_ptr = ptr + 1'b1;
                if (cnt == '0) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
        endcase
    end

    // FSM and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= nxt_state;
            owner      <= nxt_owner;
            we_q       <= nxt_we;
            ptr        <= nxt_ptr;
            cnt        <= nxt_cnt;
            last_owner <= nxt_last;
        end
    end

    // Per-requester read-valid pulse and last-value hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            hold0   <= '0;
            hold1   <= '0;
        end else begin
            rvalid0 <= mem_re & ~owner;
            rvalid1 <= mem_re &  owner;
            if (rvalid0) begin
                hold0 <= mem_rdata;
            end
            if (rvalid1) begin
                hold1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Bench for mem_burst_arbiter: directed and random bursts
// checked against an array model of the memory.
module tb_mem_burst_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1, len0, len1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, ack0, ack1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem_m [16];
    logic [7:0] wbuf [16];
    logic [7:0] exp_rd [2];

    always #5 clk = ~clk;

    mem_burst_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .len0   (len0),
        .len1   (len1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rvalid0(rvalid0),
        .rvalid1(rvalid1),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input int r);
        return (r != 0) ? gnt1 : gnt0;
    endfunction
    function automatic logic ack_of(input int r);
        return (r != 0) ? ack1 : ack0;
    endfunction
    function automatic logic rv_of(input int r);
        return (r != 0) ? rvalid1 : rvalid0;
    endfunction
    function automatic logic [7:0] rd_of(input int r);
        return (r != 0) ? rdata1 : rdata0;
    endfunction

    task automatic drive_req(input int r, input logic v, input logic w,
                             input logic [3:0] a, input logic [3:0] l);
        if (r == 0) begin
            req0 = v; we0 = w; addr0 = a; len0 = l;
        end else begin
            req1 = v; we1 = w; addr1 = a; len1 = l;
        end
    endtask

    task automatic set_wdata(input int r, input logic [7:0] d);
        if (r == 0) wdata0 = d;
        else        wdata1 = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  {30'd0, gnt1, gnt0}, 32'd0);
        chk({tag, "_ack"},  {30'd0, ack1, ack0}, 32'd0);
        chk({tag, "_rv"},   {30'd0, rvalid1, rvalid0}, 32'd0);
        chk({tag, "_rd0"},  {24'd0, rdata0}, 32'd0);
        chk({tag, "_rd1"},  {24'd0, rdata1}, 32'd0);
    endtask

    // One burst by requester r from an IDLE cycle. Called at a negedge.
    // drop_at: beat index where req falls; rst_at: beat index of reset.
    task automatic run_burst(input int r, input logic w,
                             input logic [3:0] a, input logic [3:0] l,
                             input int drop_at, input int rst_at);
        int o;
        int ngnt;
        logic [3:0] p;
        o = 1 - r;
        ngnt = 0;
        drive_req(r, 1'b1, w, a, l);
        @(negedge clk);
        for (int i = 0; i <= int'(l); i++) begin
            p = a + 4'(i);
            ngnt += int'(gnt_of(r));
            chk("gnt_own",   {31'd0, gnt_of(r)}, 32'd1);
            chk("gnt_other", {31'd0, gnt_of(o)}, 32'd0);
            chk("ack_own",   {31'd0, ack_of(r)}, 32'd1);
            chk("ack_other", {31'd0, ack_of(o)}, 32'd0);
            chk("rv_own",    {31'd0, rv_of(r)}, {31'd0, (i > 0) && !w});
            chk("rd_own",    {24'd0, rd_of(r)}, {24'd0, exp_rd[r]});
            chk("rv_other",  {31'd0, rv_of(o)}, 32'd0);
            chk("rd_other",  {24'd0, rd_of(o)}, {24'd0, exp_rd[o]});
            if (i == drop_at) drive_req(r, 1'b0, w, a, l);
            if (i == rst_at) begin
                set_wdata(r, wbuf[i]);
                reset = 1'b1;
                drive_req(r, 1'b0, w, a, l);
                @(negedge clk);
                reset = 1'b0;
                exp_rd[0] = 8'h00;
                exp_rd[1] = 8'h00;
                chk_all_zero("rst_mid");
                return;
            end
            if (w) begin
                set_wdata(r, wbuf[i]);
                mem_m[p] = wbuf[i];
            end else begin
                exp_rd[r] = mem_m[p];
            end
            @(negedge clk);
        end
        chk("gnt_cycles", ngnt, int'(l) + 1);
        chk("gnt_end", {30'd0, gnt1, gnt0}, 32'd0);
        chk("ack_end", {30'd0, ack1, ack0}, 32'd0);
        chk("rv_last", {31'd0, rv_of(r)}, {31'd0, !w});
        chk("rd_last", {24'd0, rd_of(r)}, {24'd0, exp_rd[r]});
        @(negedge clk);
        chk("rv_idle", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rd_hold", {24'd0, rd_of(r)}, {24'd0, exp_rd[r]});
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
        wdata0 = 0; wdata1 = 0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Fill the whole memory so every later read has a known value.
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        run_burst(0, 1'b1, 4'h0, 4'hF, 0, -1);

        // Simultaneous requests after reset alternate starting with 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        drive_req(0, 1'b1, 1'b0, 4'h2, 4'h0);
        drive_req(1, 1'b1, 1'b0, 4'h9, 4'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("alt_gnt0", {31'd0, gnt0}, {31'd0, (c % 4) == 0});
            chk("alt_gnt1", {31'd0, gnt1}, {31'd0, (c % 4) == 2});
            chk("alt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
            chk("alt_rv0", {31'd0, rvalid0}, {31'd0, (c % 4) == 1});
            chk("alt_rv1", {31'd0, rvalid1}, {31'd0, (c % 4) == 3});
            if ((c % 4) == 1) chk("alt_rd0", {24'd0, rdata0}, {24'd0, mem_m[2]});
            if ((c % 4) == 3) chk("alt_rd1", {24'd0, rdata1}, {24'd0, mem_m[9]});
        end
        drive_req(0, 1'b0, 1'b0, 4'h0, 4'h0);
        drive_req(1, 1'b0, 1'b0, 4'h0, 4'h0);
        exp_rd[0] = mem_m[2];
        exp_rd[1] = mem_m[9];
        @(negedge clk);

        // Write with address wrap, then read it back.
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
        run_burst(0, 1'b1, 4'hE, 4'h3, 0, -1);
        run_burst(0, 1'b0, 4'hE, 4'h3, 0, -1);
        chk("wrap_last", {24'd0, rdata0}, 32'h0000_00A3);
        run_burst(1, 1'b0, 4'h0, 4'h0, 0, -1);
        chk("wrap_addr0", {24'd0, rdata1}, 32'h0000_00A2);

        // Reset on the 4th ack of a len-7 write from address 0.
        for (int i = 0; i < 8; i++) wbuf[i] = 8'hC0 + 8'(i);
        run_burst(0, 1'b1, 4'h0, 4'h7, 0, 3);
        run_burst(0, 1'b0, 4'h0, 4'h7, 0, -1);

        // Request dropped one cycle into a len-5 read.
        run_burst(1, 1'b0, 4'h3, 4'h5, 1, -1);

        // Cross-requester visibility.
        wbuf[0] = 8'h5A;
        run_burst(1, 1'b1, 4'h7, 4'h0, 0, -1);
        run_burst(0, 1'b0, 4'h7, 4'h0, 0, -1);
        chk("cross_rd0", {24'd0, rdata0}, 32'h0000_005A);

        // Max burst from address 5 wraps fully around.
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        run_burst(1, 1'b1, 4'h5, 4'hF, 0, -1);
        run_burst(0, 1'b0, 4'h5, 4'hF, 0, -1);

        // Random bursts.
        for (int n = 0; n < 24; n++) begin
            int r;
            logic w;
            logic [3:0] a, l;
            r = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            run_burst(r, w, a, l, 0, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
